// File: rtl/serial_comparator_5bits.sv
// Bit-serial comparator for two WIDTH-bit unsigned operands, MSB first.
// Define SERIAL_CMP_MAGNITUDE_EN to add gt/lt outputs; otherwise the block is equality-only.
module serial_comparator_5bits #(
    parameter int WIDTH = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic bit_valid,
    input  logic a_bit,
    input  logic b_bit,
    output logic busy,
    output logic done,
    output logic eq,
    output logic gt,
    output logic lt
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          decided;
    logic          decided_next;
    logic          last_pair;

`ifdef SERIAL_CMP_MAGNITUDE_EN
    logic a_gt;
    logic a_gt_next;
`endif

    // Decision tracking for the pair on the inputs: the first differing pair wins.
    always_comb begin
        decided_next = decided | (a_bit ^ b_bit);
        last_pair    = (count == CW'(WIDTH - 1));
`ifdef SERIAL_CMP_MAGNITUDE_EN
        if (decided) begin
            a_gt_next = a_gt;
        end else begin
            a_gt_next = a_bit;
        end
`endif
    end

    // Control FSM with registered busy/done and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            decided <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            eq      <= 1'b0;
`ifdef SERIAL_CMP_MAGNITUDE_EN
            a_gt    <= 1'b0;
            gt      <= 1'b0;
            lt      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= SHIFT;
                        busy    <= 1'b1;
                        count   <= '0;
                        decided <= 1'b0;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (bit_valid) begin
                        count   <= count + CW'(1);
                        decided <= decided_next;
`ifdef SERIAL_CMP_MAGNITUDE_EN
                        a_gt    <= a_gt_next;
`endif
                        // Results land on the same edge that consumes the final pair,
                        // so they are already visible during the DONE cycle.
                        if (last_pair) begin
                            state <= DONE;
                            done  <= 1'b1;
                            eq    <= ~decided_next;
`ifdef SERIAL_CMP_MAGNITUDE_EN
                            gt    <= decided_next & a_gt_next;
                            lt    <= decided_next & ~a_gt_next;
`endif
                        end else begin
                            state <= SHIFT;
                        end
                    end else begin
                        state <= SHIFT;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifndef SERIAL_CMP_MAGNITUDE_EN
    assign gt = 1'b0;
    assign lt = 1'b0;
`endif

endmodule

// File: tb/tb_serial_comparator_5bits.sv
// Scoreboard bench for serial_comparator_5bits: driver pushes expected results,
// a negedge monitor pops and compares whenever done is presented.
module tb_serial_comparator_5bits;

    localparam int WIDTH = 5;

    logic clk = 1'b0;
    logic reset, start, bit_valid, a_bit, b_bit;
    logic busy, done, eq, gt, lt;

    typedef struct {
        logic [2:0] res;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         compared = 0;
    int         mismatched = 0;
    logic [2:0] prev_res = 3'b000;
    logic       prev_done = 1'b0;

    serial_comparator_5bits #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .start(start), .bit_valid(bit_valid),
        .a_bit(a_bit), .b_bit(b_bit), .busy(busy), .done(done),
        .eq(eq), .gt(gt), .lt(lt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function void check(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: plain unsigned arithmetic on the whole operands.
    function automatic logic [2:0] model(int a, int b);
`ifdef SERIAL_CMP_MAGNITUDE_EN
        return {a == b, a > b, a < b};
`else
        return {a == b, 1'b0, 1'b0};
`endif
    endfunction

    // Monitor: compare every done against the oldest expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("done_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result_eq_gt_lt", {eq, gt, lt}, e.res);
                check("done_cycle", cyc, e.cyc);
`ifdef SERIAL_CMP_MAGNITUDE_EN
                check("result_onehot", $countones({eq, gt, lt}), 1);
`endif
            end
            check("done_width", prev_done, 1'b0);
        end
        prev_done <= done;
    end

    task automatic run_op(input int a, input int b, input int stall_pos,
                          input int stall_len, input bit restart);
        exp_t e;
        @(negedge clk);
        check("busy_idle", busy, 1'b0);
        start     = 1'b1;
        bit_valid = 1'($urandom_range(0, 1));
        a_bit     = 1'($urandom_range(0, 1));
        b_bit     = 1'($urandom_range(0, 1));
        e.res = model(a, b);
        e.cyc = cyc + 1 + WIDTH + stall_len;
        exp_q.push_back(e);
        for (int i = 0; i < WIDTH; i++) begin
            if (i == stall_pos) begin
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    start     = 1'b0;
                    bit_valid = 1'b0;
                    a_bit     = 1'($urandom_range(0, 1));
                    b_bit     = 1'($urandom_range(0, 1));
                    check("stall_busy", busy, 1'b1);
                    check("stall_hold", {eq, gt, lt}, prev_res);
                end
            end
            @(negedge clk);
            start     = restart && (i == 2);
            bit_valid = 1'b1;
            a_bit     = 1'((a >> (WIDTH - 1 - i)) & 1);
            b_bit     = 1'((b >> (WIDTH - 1 - i)) & 1);
            check("busy_shift", busy, 1'b1);
            if (i > 0) check("shift_hold", {eq, gt, lt}, prev_res);
        end
        // DONE cycle: a pair offered here must be dropped.
        @(negedge clk);
        start     = 1'b0;
        bit_valid = 1'b1;
        a_bit     = 1'($urandom_range(0, 1));
        b_bit     = 1'($urandom_range(0, 1));
        check("busy_done", busy, 1'b1);
        prev_res = e.res;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            start     = 1'b0;
            bit_valid = 1'b1;
            a_bit     = 1'($urandom_range(0, 1));
            b_bit     = 1'($urandom_range(0, 1));
            check("idle_busy", busy, 1'b0);
            check("idle_hold", {eq, gt, lt}, prev_res);
        end
    endtask

    task automatic reset_mid_op();
        @(negedge clk);
        start = 1'b1; bit_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            start = 1'b0; bit_valid = 1'b1;
            a_bit = 1'b1; b_bit = 1'b0;
        end
        @(negedge clk);
        reset = 1'b1; bit_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0; bit_valid = 1'b0;
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_done", done, 1'b0);
        check("rst_mid_results", {eq, gt, lt}, 3'b000);
        prev_res = 3'b000;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_results", {eq, gt, lt}, 3'b000);
        reset = 1'b0;

        run_op(5'b00001, 5'b00001, -1, 0, 1'b0);
        run_op(5'b10000, 5'b01111, -1, 0, 1'b0);
        run_op(5'b01111, 5'b10000, -1, 0, 1'b0);
        run_op(5'b00010, 5'b00001, 2, 2, 1'b0);
        run_op(5'b11111, 5'b11111, -1, 0, 1'b1);
        idle(3);
        run_op(5'b10101, 5'b10100, -1, 0, 1'b0);
        reset_mid_op();
        run_op(5'b00101, 5'b01001, -1, 0, 1'b0);
        run_op(5'b11111, 5'b11110, -1, 0, 1'b0);
        run_op(5'b00000, 5'b00000, -1, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            int a, b, sp, sl;
            a  = int'($urandom_range(0, 31));
            b  = ($urandom_range(0, 3) == 0) ? a : int'($urandom_range(0, 31));
            sp = int'($urandom_range(0, WIDTH));
            sl = (sp < WIDTH) ? int'($urandom_range(1, 3)) : 0;
            idle(int'($urandom_range(0, 1)));
            run_op(a, b, sp, sl, 1'($urandom_range(0, 1)));
        end

        idle(3);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
